// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit display scan controller.
// The lamp-test option (DISP_LAMP_TEST_EN) uses LAMP_TEST_IMAGE from here.
package disp_pkg;

    localparam int IMG_W       = 20;
    localparam int FRAME_LEN   = 4;
    localparam int PWM_FRAMES  = 16;
    localparam int FRAME_CNT_W = $clog2(FRAME_LEN);
    localparam int PWM_CNT_W   = $clog2(PWM_FRAMES);
    localparam int HOLD_W      = 16;

    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAME_LEN - 1);
    localparam logic [PWM_CNT_W-1:0]   PWM_LAST   = PWM_CNT_W'(PWM_FRAMES - 1);
    localparam logic [IMG_W-1:0]       LAMP_TEST_IMAGE = 20'hF8888;

    typedef enum logic {
        SRC_STATUS = 1'b0,
        SRC_HOST   = 1'b1
    } src_state_e;

    // PWM count the coming frame will carry; wraps at the period end.
    function automatic logic [PWM_CNT_W-1:0] pwm_next(input logic [PWM_CNT_W-1:0] cnt);
        return cnt + PWM_CNT_W'(1);
    endfunction

endpackage

// File: rtl/disp_frame_pwm.sv
// Frame (digit scan) and PWM frame counters plus the frame-aligned driver enable.
// With DISP_LAMP_TEST_EN defined, lamp_test forces the enable on from the next frame.
module disp_frame_pwm
    import disp_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PWM_CNT_W-1:0] brightness,
`ifdef DISP_LAMP_TEST_EN
    input  logic                 lamp_test,
`endif
    output logic                 frame_tick,
    output logic                 period_tick,
    output logic                 drv_oe
);

    logic [FRAME_CNT_W-1:0] frame_cnt_r;
    logic [PWM_CNT_W-1:0]   pwm_cnt_r;
    logic                   oe_r;
    logic                   oe_next_s;

    // Boundary decodes and the enable value for the frame about to start.
    always_comb begin
        frame_tick  = (frame_cnt_r == FRAME_LAST);
        period_tick = frame_tick && (pwm_cnt_r == PWM_LAST);
        oe_next_s   = (pwm_next(pwm_cnt_r) < brightness);
`ifdef DISP_LAMP_TEST_EN
        if (lamp_test) begin
            oe_next_s = 1'b1;
        end else begin
            oe_next_s = (pwm_next(pwm_cnt_r) < brightness);
        end
`endif
    end

    // Free-running counters; the enable only moves on frame boundaries.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt_r <= '0;
            pwm_cnt_r   <= '0;
            oe_r        <= 1'b0;
        end else begin
            frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
            if (frame_tick) begin
                pwm_cnt_r <= pwm_next(pwm_cnt_r);
                oe_r      <= oe_next_s;
            end
        end
    end

    assign drv_oe = oe_r;

endmodule

// File: rtl/display_scan_ctrl.sv
// Selects between a timed host image and the status image for the scan driver.
// Optional lamp test enabled by defining DISP_LAMP_TEST_EN.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned HOLD_PERIODS = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 host_wr,
    input  logic [IMG_W-1:0]     host_data,
    output logic                 host_ack,
    input  logic                 host_sticky,
    input  logic [IMG_W-1:0]     stat_data,
    input  logic [PWM_CNT_W-1:0] brightness,
`ifdef DISP_LAMP_TEST_EN
    input  logic                 lamp_test,
`endif
    output logic [IMG_W-1:0]     drv_data,
    output logic                 drv_oe,
    output logic                 src_host
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_PERIODS);

    src_state_e        state_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [IMG_W-1:0]  host_img_r;
    logic [IMG_W-1:0]  drv_data_r;
    logic              ack_r;

    logic              frame_tick_s;
    logic              period_tick_s;
    logic              countdown_s;
    logic              timeout_s;
    logic              show_host_s;
    logic [IMG_W-1:0]  frame_img_s;

    disp_frame_pwm u_frame_pwm (
        .clock       (clock),
        .reset       (reset),
        .brightness  (brightness),
`ifdef DISP_LAMP_TEST_EN
        .lamp_test   (lamp_test),
`endif
        .frame_tick  (frame_tick_s),
        .period_tick (period_tick_s),
        .drv_oe      (drv_oe)
    );

    // Hold countdown conditions and the image latched at the coming boundary.
    // A timeout boundary already shows status unless a write keeps the host image.
    always_comb begin
        countdown_s = (state_r == SRC_HOST) && period_tick_s && !host_sticky;
        timeout_s   = countdown_s && (hold_cnt_r == HOLD_W'(1));
        show_host_s = (state_r == SRC_HOST) && !(timeout_s && !host_wr);
        if (show_host_s) begin
            frame_img_s = host_img_r;
        end else begin
            frame_img_s = stat_data;
        end
`ifdef DISP_LAMP_TEST_EN
        if (lamp_test) begin
            frame_img_s = LAMP_TEST_IMAGE;
        end else if (show_host_s) begin
            frame_img_s = host_img_r;
        end else begin
            frame_img_s = stat_data;
        end
`endif
    end

    // Source FSM, hold counter, host image register, ack and driver image.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= SRC_STATUS;
            hold_cnt_r <= '0;
            host_img_r <= '0;
            drv_data_r <= '0;
            ack_r      <= 1'b0;
        end else begin
            ack_r <= host_wr;
            if (frame_tick_s) begin
                drv_data_r <= frame_img_s;
            end
            if (host_wr) begin
                host_img_r <= host_data;
                hold_cnt_r <= HOLD_LOAD;
                state_r    <= SRC_HOST;
            end else begin
                case (state_r)
                    SRC_STATUS: state_r <= SRC_STATUS;
                    SRC_HOST: begin
                        if (countdown_s) begin
                            hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
                            if (timeout_s) begin
                                state_r <= SRC_STATUS;
                            end
                        end
                    end
                    default: state_r <= SRC_STATUS;
                endcase
            end
        end
    end

    assign drv_data = drv_data_r;
    assign host_ack = ack_r;
    assign src_host = (state_r == SRC_HOST);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a cycle-count based reference model.
module tb_display_scan_ctrl;

    localparam int HOLD = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        host_wr;
    logic [19:0] host_data;
    logic        host_ack;
    logic        host_sticky;
    logic [19:0] stat_data;
    logic [3:0]  brightness;
    logic [19:0] drv_data;
    logic        drv_oe;
    logic        src_host;
`ifdef DISP_LAMP_TEST_EN
    logic        lamp_test = 1'b0;
`endif

    display_scan_ctrl #(.HOLD_PERIODS(HOLD)) dut (
        .clock       (clock),
        .reset       (reset),
        .host_wr     (host_wr),
        .host_data   (host_data),
        .host_ack    (host_ack),
        .host_sticky (host_sticky),
        .stat_data   (stat_data),
        .brightness  (brightness),
`ifdef DISP_LAMP_TEST_EN
        .lamp_test   (lamp_test),
`endif
        .drv_data    (drv_data),
        .drv_oe      (drv_oe),
        .src_host    (src_host)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference: t counts clock edges since reset release; frame k = t/4,
    // a boundary edge is t%4==3, a period end is the boundary closing frame 15.
    int          t = 0;
    bit          m_host = 1'b0;
    int          m_hold = 0;
    logic [19:0] m_img = 20'h0;
    logic [19:0] m_data = 20'h0;
    bit          m_oe = 1'b0;
    bit          m_ack = 1'b0;
    bit          last_pe = 1'b0;

    task automatic chk(input string tag, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, act, exp, t);
        end
    endtask

    task automatic step();
        bit boundary;
        bit expire;
        bit lamp;
        int next_pwm;
        @(posedge clock);
        lamp = 1'b0;
`ifdef DISP_LAMP_TEST_EN
        lamp = lamp_test;
`endif
        last_pe = 1'b0;
        if (reset) begin
            t = 0; m_host = 1'b0; m_hold = 0; m_img = 20'h0;
            m_data = 20'h0; m_oe = 1'b0; m_ack = 1'b0;
        end else begin
            boundary = (t % 4) == 3;
            last_pe  = boundary && ((t / 4) % 16 == 15);
            next_pwm = (t / 4 + 1) % 16;
            expire   = m_host && last_pe && !host_sticky && m_hold == 1 && !host_wr;
            if (boundary) begin
                m_oe   = lamp || (next_pwm < int'(brightness));
                m_data = lamp ? 20'hF8888 : ((m_host && !expire) ? m_img : stat_data);
            end
            m_ack = host_wr;
            if (host_wr) begin
                m_img = host_data; m_host = 1'b1; m_hold = HOLD;
            end else if (m_host && last_pe && !host_sticky) begin
                m_hold--;
                if (m_hold == 0) m_host = 1'b0;
            end
            t++;
        end
        @(negedge clock);
        chk("drv_data", drv_data, m_data);
        chk("drv_oe", 20'(drv_oe), 20'(m_oe));
        chk("host_ack", 20'(host_ack), 20'(m_ack));
        chk("src_host", 20'(src_host), 20'(m_host));
    endtask

    task automatic run_random(input int n, input int wr_permille, input bit vary);
        for (int i = 0; i < n; i++) begin
            host_wr   = ($urandom_range(0, 999) < wr_permille);
            host_data = 20'($urandom);
            if ($urandom_range(0, 7) == 0) stat_data = 20'($urandom);
            if (vary && $urandom_range(0, 99) == 0) host_sticky = ~host_sticky;
            if (vary && $urandom_range(0, 199) == 0) brightness = 4'($urandom);
            step();
        end
        host_wr = 1'b0;
    endtask

    initial begin
        int ones;
        int pe;
        bit hit;
        logic [19:0] saved;

        reset = 1'b1; host_wr = 1'b1; host_data = 20'hABCDE; host_sticky = 1'b0;
        stat_data = 20'h5A5A5; brightness = 4'd4;
        for (int i = 0; i < 3; i++) step();
        chk("reset_data", drv_data, 20'h0);
        chk("reset_src", 20'(src_host), 20'h0);
        host_wr = 1'b0;
        reset = 1'b0;

        // Brightness 4, no writes: 16 enabled cycles per steady-state period.
        for (int i = 0; i < 64; i++) step();
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (drv_oe) ones++;
        end
        chk("oe_per_period", 20'(ones), 20'd16);

        // Mid-frame write shows on the next boundary, ack one cycle later.
        for (int i = 0; i < 8 && (t % 4) != 1; i++) step();
        host_wr = 1'b1; host_data = 20'h11234;
        step();
        host_wr = 1'b0;
        chk("ack_pulse", 20'(host_ack), 20'h1);
        step();
        chk("ack_single", 20'(host_ack), 20'h0);
        for (int i = 0; i < 8 && (t % 4) != 0; i++) step();
        chk("host_img", drv_data, 20'h11234);
        chk("host_src", 20'(src_host), 20'h1);

        // Timeout after exactly HOLD period ends, on a period boundary.
        pe = 0;
        for (int i = 0; i < 300 && src_host; i++) begin
            step();
            if (last_pe) pe++;
        end
        chk("revert_periods", 20'(pe), 20'(HOLD));
        chk("revert_align", 20'(t % 64), 20'h0);
        chk("revert_img", drv_data, stat_data);

        // Write landing on the timeout cycle keeps the host image selected.
        host_wr = 1'b1; host_data = 20'h0CAFE;
        step();
        host_wr = 1'b0;
        hit = 1'b0;
        saved = 20'h0;
        for (int i = 0; i < 400 && !hit; i++) begin
            host_data = 20'($urandom);
            if (m_host && m_hold == 1 && (t % 64) == 63) begin
                host_wr = 1'b1; hit = 1'b1; saved = host_data;
            end
            step();
            host_wr = 1'b0;
        end
        chk("timeout_hit", 20'(hit), 20'h1);
        chk("wr_beats_timeout", 20'(src_host), 20'h1);
        step();
        for (int i = 0; i < 8 && (t % 4) != 0; i++) step();
        chk("timeout_new_img", drv_data, saved);

        // Mixed random traffic: writes, sticky toggling, brightness changes.
        run_random(1500, 15, 1'b1);
        host_sticky = 1'b0;

        // Reset mid-hold while the driver is enabled.
        brightness = 4'd15;
        host_wr = 1'b1; host_data = 20'h98765;
        step();
        host_wr = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            hit = src_host && drv_oe && (t % 4) == 1;
        end
        chk("oe_before_reset", 20'(hit), 20'h1);
        reset = 1'b1;
        step();
        chk("rst_oe", 20'(drv_oe), 20'h0);
        chk("rst_data", drv_data, 20'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("first_frame_dark", 20'(drv_oe), 20'h0);
        end
        step();
        chk("second_frame_on", 20'(drv_oe), 20'h1);

`ifdef DISP_LAMP_TEST_EN
        brightness = 4'd0;
        for (int i = 0; i < 8 && (t % 4) != 1; i++) step();
        lamp_test = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("lamp_data", drv_data, 20'hF8888);
        chk("lamp_oe", 20'(drv_oe), 20'h1);
        lamp_test = 1'b0;
        for (int i = 0; i < 8; i++) step();
`endif

        run_random(400, 5, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
